// File: rtl/param_fifo_if.sv
// Handshake bundle between a producer/consumer pair and param_fifo.
// master = the stage driving push/pop requests, slave = the FIFO itself.
interface param_fifo_if #(
  parameter int DEPTH = 8,
  parameter int LANES = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LANES-1:0][31:0] FIFO_in;
  logic                   FIFO_WEN;
  logic                   FIFO_REN;
  logic                   FIFO_FLUSH;
  logic                   FIFO_clr_err;
  logic [LANES-1:0][31:0] FIFO_out;
  logic                   FIFO_valid;
  logic                   FIFO_empty;
  logic                   FIFO_full;
  logic                   FIFO_almost_full;
  logic                   FIFO_almost_empty;
  logic [CW-1:0]          FIFO_count;
  logic                   FIFO_overflow;
  logic                   FIFO_underflow;

  modport master (
    output FIFO_in, FIFO_WEN, FIFO_REN, FIFO_FLUSH, FIFO_clr_err,
    input  FIFO_out, FIFO_valid, FIFO_empty, FIFO_full, FIFO_almost_full,
           FIFO_almost_empty, FIFO_count, FIFO_overflow, FIFO_underflow
  );

  modport slave (
    input  FIFO_in, FIFO_WEN, FIFO_REN, FIFO_FLUSH, FIFO_clr_err,
    output FIFO_out, FIFO_valid, FIFO_empty, FIFO_full, FIFO_almost_full,
           FIFO_almost_empty, FIFO_count, FIFO_overflow, FIFO_underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised synchronous multi-lane FIFO with occupancy/threshold status,
// flush, full-with-pop acceptance, sticky error flags and FWFT/registered read.
module param_fifo #(
   parameter int DEPTH    = 8,
   parameter int LANES    = 2,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 1
) (
   input logic          CLK,
   input logic          RST,
   param_fifo_if.slave  fifo
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [31:0] word_t;
   typedef word_t [LANES-1:0] entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;
   logic            empty, full, pop_ok, push_ok;
   logic            overflow, underflow;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = fifo.FIFO_REN & ~empty;
   assign push_ok = fifo.FIFO_WEN & (~full | pop_ok);

   // NOTE: memory gets the async reset too, so the array is cleared without a clock edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!fifo.FIFO_FLUSH && push_ok) begin
         mem[wr_ptr] <= fifo.FIFO_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (fifo.FIFO_FLUSH) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Set beats clear; a flush cycle never raises an error.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (~fifo.FIFO_FLUSH & fifo.FIFO_WEN & ~push_ok)
                    | (overflow & ~fifo.FIFO_clr_err);
         underflow <= (~fifo.FIFO_FLUSH & fifo.FIFO_REN & empty)
                    | (underflow & ~fifo.FIFO_clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign fifo.FIFO_out   = empty ? '0 : mem[rd_ptr];
         assign fifo.FIFO_valid = ~empty;
      end else begin : g_reg
         entry_t out_q;
         logic   valid_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               out_q   <= '0;
               valid_q <= 1'b0;
            end else if (fifo.FIFO_FLUSH) begin
               valid_q <= 1'b0;
            end else if (pop_ok) begin
               out_q   <= mem[rd_ptr];
               valid_q <= 1'b1;
            end else begin
               valid_q <= 1'b0;
            end
         end

         assign fifo.FIFO_out   = out_q;
         assign fifo.FIFO_valid = valid_q;
      end
   endgenerate

   assign fifo.FIFO_empty        = empty;
   assign fifo.FIFO_full         = full;
   assign fifo.FIFO_almost_full  = (count >= CW'(AF_LEVEL));
   assign fifo.FIFO_almost_empty = (count <= CW'(AE_LEVEL));
   assign fifo.FIFO_count        = count;
   assign fifo.FIFO_overflow     = overflow;
   assign fifo.FIFO_underflow    = underflow;
endmodule
